uart_rx_frame_ctrl: RTL

Frame-level controller placed directly behind the UART receiver. It consumes the receiver's byte/valid-pulse stream and parses frames of the form header, length, payload, checksum. Complete payloads are buffered and released on a valid/ready stream only after the checksum passes; malformed, oversized or stalled frames are discarded and reported.

---
 rtl/uart_frame_pkg.sv | 20 ++
 rtl/uart_frame_buf.sv | 24 ++
 rtl/uart_rx_frame_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART frame controller: FSM states, error codes
// and the default start-of-frame marker.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHECK,
    ST_DRAIN
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] FRAME_HEAD_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: register array with a synchronous write port and a
// combinational read port.
module uart_frame_buf #(
  parameter int unsigned P_DEPTH = 16,
  parameter int unsigned P_WIDTH = 8,
  parameter int unsigned P_AW    = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1
) (
  input  logic               clk,
  input  logic               we,
  input  logic [P_AW-1:0]    waddr,
  input  logic [P_WIDTH-1:0] wdata,
  input  logic [P_AW-1:0]    raddr,
  output logic [P_WIDTH-1:0] rdata
);

  logic [P_WIDTH-1:0] mem [0:P_DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frame parser behind the UART receiver: header, length, payload, checksum.
// Payload is released on a valid/ready stream only after the checksum passes.
module uart_rx_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter int unsigned P_UART_DATA_WIDTH = 8,
  parameter logic [P_UART_DATA_WIDTH-1:0] P_FRAME_HEAD = FRAME_HEAD_DEFAULT,
  parameter int unsigned P_MAX_LEN = 16,
  parameter int unsigned P_TIMEOUT = 40
) (
  input  logic                         i_u_clk,
  input  logic                         i_u_rst,
  input  logic [P_UART_DATA_WIDTH-1:0] i_rx_data,
  input  logic                         i_rx_valid,
  output logic [P_UART_DATA_WIDTH-1:0] o_pld_data,
  output logic                         o_pld_valid,
  output logic                         o_pld_last,
  input  logic                         i_pld_ready,
  output logic                         o_frame_ok,
  output logic                         o_frame_err,
  output logic [1:0]                   o_err_code,
  output logic                         o_overrun,
  output logic                         o_busy
);

  localparam int unsigned DW = P_UART_DATA_WIDTH;
  localparam int unsigned IW = $clog2(P_MAX_LEN) + 1;
  localparam int unsigned AW = (P_MAX_LEN > 1) ? $clog2(P_MAX_LEN) : 1;
  localparam int unsigned TW = $clog2(P_TIMEOUT) + 1;
  localparam logic [DW-1:0] MAX_LEN_B = DW'(P_MAX_LEN);
  localparam logic [TW-1:0] TMO_LIM   = TW'(P_TIMEOUT);

  state_t        state, state_n;
  logic [IW-1:0] len, len_n;
  logic [IW-1:0] wr_idx, wr_n;
  logic [IW-1:0] rd_idx, rd_n;
  logic [DW-1:0] csum, csum_n;
  logic [TW-1:0] tmo, tmo_n;
  logic          ok_q, ok_n;
  logic          err_q, err_n;
  logic [1:0]    code_q, code_n;
  logic          ovr_q, ovr_n;
  logic          we;
  logic [DW-1:0] rdata;
  logic          draining;

  uart_frame_buf #(
    .P_DEPTH (P_MAX_LEN),
    .P_WIDTH (DW),
    .P_AW    (AW)
  ) u_buf (
    .clk   (i_u_clk),
    .we    (we),
    .waddr (wr_idx[AW-1:0]),
    .wdata (i_rx_data),
    .raddr (rd_idx[AW-1:0]),
    .rdata (rdata)
  );

  always_ff @(posedge i_u_clk or posedge i_u_rst) begin
    if (i_u_rst) begin
      state  <= ST_IDLE;
      len    <= '0;
      wr_idx <= '0;
      rd_idx <= '0;
      csum   <= '0;
      tmo    <= '0;
      ok_q   <= 1'b0;
      err_q  <= 1'b0;
      code_q <= ERR_NONE;
      ovr_q  <= 1'b0;
    end else begin
      state  <= state_n;
      len    <= len_n;
      wr_idx <= wr_n;
      rd_idx <= rd_n;
      csum   <= csum_n;
      tmo    <= tmo_n;
      ok_q   <= ok_n;
      err_q  <= err_n;
      code_q <= code_n;
      ovr_q  <= ovr_n;
    end
  end

  always_comb begin
    state_n = state;
    len_n   = len;
    wr_n    = wr_idx;
    rd_n    = rd_idx;
    csum_n  = csum;
    tmo_n   = tmo;
    ok_n    = 1'b0;
    err_n   = 1'b0;
    code_n  = code_q;
    ovr_n   = 1'b0;
    we      = 1'b0;

    // Byteless cycles inside a frame age the inter-byte timer; a byte in the
    // same cycle as expiry takes priority via the case below.
    if ((state == ST_LEN || state == ST_PAYLOAD || state == ST_CHECK) && !i_rx_valid) begin
      if (tmo == TMO_LIM) begin
        state_n = ST_IDLE;
        err_n   = 1'b1;
        code_n  = ERR_TIMEOUT;
        wr_n    = '0;
        rd_n    = '0;
        csum_n  = '0;
        tmo_n   = '0;
      end else begin
        tmo_n = tmo + 1'b1;
      end
    end

    case (state)
      ST_IDLE: begin
        if (i_rx_valid && i_rx_data == P_FRAME_HEAD) begin
          state_n = ST_LEN;
          tmo_n   = '0;
        end
      end
      ST_LEN: begin
        if (i_rx_valid) begin
          tmo_n = '0;
          if (i_rx_data == '0 || i_rx_data > MAX_LEN_B) begin
            state_n = ST_IDLE;
            err_n   = 1'b1;
            code_n  = ERR_LEN;
            wr_n    = '0;
            rd_n    = '0;
            csum_n  = '0;
          end else begin
            state_n = ST_PAYLOAD;
            len_n   = IW'(i_rx_data);
            csum_n  = i_rx_data;
            wr_n    = '0;
          end
        end
      end
      ST_PAYLOAD: begin
        if (i_rx_valid) begin
          tmo_n  = '0;
          we     = 1'b1;
          csum_n = csum ^ i_rx_data;
          wr_n   = wr_idx + 1'b1;
          if (wr_idx + 1'b1 == len) state_n = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (i_rx_valid) begin
          tmo_n = '0;
          if (i_rx_data == csum) begin
            state_n = ST_DRAIN;
            ok_n    = 1'b1;
            rd_n    = '0;
          end else begin
            state_n = ST_IDLE;
            err_n   = 1'b1;
            code_n  = ERR_CSUM;
            wr_n    = '0;
            rd_n    = '0;
            csum_n  = '0;
          end
        end
      end
      ST_DRAIN: begin
        if (i_rx_valid) ovr_n = 1'b1;
        if (i_pld_ready) begin
          if (rd_idx == len - 1'b1) begin
            state_n = ST_IDLE;
            rd_n    = '0;
          end else begin
            rd_n = rd_idx + 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign draining    = (state == ST_DRAIN);
  assign o_pld_valid = draining;
  assign o_pld_data  = draining ? rdata : '0;
  assign o_pld_last  = draining && (rd_idx == len - 1'b1);
  assign o_frame_ok  = ok_q;
  assign o_frame_err = err_q;
  assign o_err_code  = code_q;
  assign o_overrun   = ovr_q;
  assign o_busy      = (state != ST_IDLE);

endmodule
